// File: rtl/wptr_full_ctrl.sv
// Write-side pointer/flag controller: binary address, Gray pointer, full/almost-full/level/overflow.
// Latency: every output updates on the wclk edge that accepts the write or samples the new wq2_rptr.
// Backpressure: wfull refuses the very next write; refused writes are dropped and set woverflow.
module wptr_full_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic                  winc,
    input  logic                  wclr_ovf,
    input  logic [ADDR_WIDTH:0]   wq2_rptr,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic                  wfull,
    output logic                  wafull,
    output logic [ADDR_WIDTH:0]   wlevel,
    output logic                  woverflow
);

    localparam int PW  = ADDR_WIDTH + 1;
    localparam int MSB = ADDR_WIDTH;
    localparam logic [PW-1:0] AFULL_T = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin_q,   wbin_d;
    logic [PW-1:0] wptr_q,   wptr_d;
    logic          wfull_q,  wfull_d;
    logic          wafull_q, wafull_d;
    logic [PW-1:0] wlevel_q, wlevel_d;
    logic          wovf_q,   wovf_d;

    logic          accept;
    logic [PW-1:0] rbin_s;
    logic [PW-1:0] full_cmp;

    // Convert the synchronised Gray read pointer back to binary for the level subtraction.
    always_comb begin
        rbin_s      = '0;
        rbin_s[MSB] = wq2_rptr[MSB];
        for (int i = MSB - 1; i >= 0; i--) begin
            rbin_s[i] = rbin_s[i+1] ^ wq2_rptr[i];
        end
    end

    // Next-state: pointer advance, full compare on the next Gray value, level and flags.
    always_comb begin
        accept   = winc & ~wfull_q;
        wbin_d   = wbin_q + PW'(accept);
        wptr_d   = (wbin_d >> 1) ^ wbin_d;
        // Full when the write pointer is exactly one lap ahead: top two Gray bits differ.
        full_cmp = {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]};
        wfull_d  = (wptr_d == full_cmp);
        wlevel_d = wbin_d - rbin_s;
        wafull_d = (wlevel_d >= AFULL_T);
        // Set has priority over clear so a refused write in the clear cycle is never lost.
        if (winc && wfull_q) begin
            wovf_d = 1'b1;
        end else if (wclr_ovf) begin
            wovf_d = 1'b0;
        end else begin
            wovf_d = wovf_q;
        end
    end

    // State registers, cleared immediately by the asynchronous reset.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wlevel_q <= '0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wlevel_q <= wlevel_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr     = wbin_q[ADDR_WIDTH-1:0];
    assign wptr      = wptr_q;
    assign wfull     = wfull_q;
    assign wafull    = wafull_q;
    assign wlevel    = wlevel_q;
    assign woverflow = wovf_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Testbench for wptr_full_ctrl: count-based scoreboard model of the write side.
// Latency: expectations are pushed as inputs are driven and popped 1 ns after the next rising edge.
// Backpressure: the model refuses writes while it believes the FIFO is full.
module tb_wptr_full_ctrl;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          wclk = 1'b0;
    logic          wrst = 1'b1;
    logic          winc = 1'b0;
    logic          wclr_ovf = 1'b0;
    logic [AW:0]   wq2_rptr = '0;
    logic [AW-1:0] waddr;
    logic [AW:0]   wptr;
    logic          wfull;
    logic          wafull;
    logic [AW:0]   wlevel;
    logic          woverflow;

    wptr_full_ctrl #(.ADDR_WIDTH(AW), .AFULL_THRESH(12)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .winc      (winc),
        .wclr_ovf  (wclr_ovf),
        .wq2_rptr  (wq2_rptr),
        .waddr     (waddr),
        .wptr      (wptr),
        .wfull     (wfull),
        .wafull    (wafull),
        .wlevel    (wlevel),
        .woverflow (woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [AW-1:0] waddr;
        logic [AW:0]   wptr;
        logic          wfull;
        logic          wafull;
        logic [AW:0]   wlevel;
        logic          wovf;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: unbounded write/read counts.
    int   m_wcnt = 0;
    int   m_rcnt = 0;
    logic m_full = 1'b0;
    logic m_ovf  = 1'b0;

    function automatic logic [AW:0] gray(input int n);
        logic [AW:0] b;
        b = AW'(0) + (AW+1)'(n % (2*DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wcnt = 0;
        m_rcnt = 0;
        m_full = 1'b0;
        m_ovf  = 1'b0;
    endtask

    task automatic set_rptr(input int n);
        m_rcnt   = n;
        wq2_rptr = gray(n);
    endtask

    // Drive one cycle of stimulus from the falling edge, push expectation, compare after the edge.
    task automatic step(input logic inc, input logic clr);
        exp_t e;
        exp_t g;
        int   lvl;
        winc     = inc;
        wclr_ovf = clr;
        if (inc && m_full) m_ovf = 1'b1;
        else if (clr)      m_ovf = 1'b0;
        if (inc && !m_full) m_wcnt++;
        lvl    = m_wcnt - m_rcnt;
        m_full = (lvl == DEPTH);
        e.waddr  = AW'(m_wcnt % DEPTH);
        e.wptr   = gray(m_wcnt);
        e.wfull  = m_full;
        e.wafull = (lvl >= 12);
        e.wlevel = (AW+1)'(lvl);
        e.wovf   = m_ovf;
        sb.push_back(e);
        @(posedge wclk);
        #1;
        g = sb.pop_front();
        chk("waddr",     {28'd0, waddr},  {28'd0, g.waddr});
        chk("wptr",      {27'd0, wptr},   {27'd0, g.wptr});
        chk("wfull",     {31'd0, wfull},  {31'd0, g.wfull});
        chk("wafull",    {31'd0, wafull}, {31'd0, g.wafull});
        chk("wlevel",    {27'd0, wlevel}, {27'd0, g.wlevel});
        chk("woverflow", {31'd0, woverflow}, {31'd0, g.wovf});
        winc     = 1'b0;
        wclr_ovf = 1'b0;
        @(negedge wclk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_waddr"},  {28'd0, waddr},  32'd0);
        chk({tag, "_wptr"},   {27'd0, wptr},   32'd0);
        chk({tag, "_wfull"},  {31'd0, wfull},  32'd0);
        chk({tag, "_wafull"}, {31'd0, wafull}, 32'd0);
        chk({tag, "_wlevel"}, {27'd0, wlevel}, 32'd0);
        chk({tag, "_wovf"},   {31'd0, woverflow}, 32'd0);
    endtask

    // Pulse reset between edges and check outputs clear without any clock edge.
    task automatic pulse_reset(input string tag);
        wrst = 1'b1;
        #1;
        chk_all_zero(tag);
        @(posedge wclk);
        @(negedge wclk);
        wrst = 1'b0;
        winc = 1'b0;
        model_reset();
        set_rptr(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wraps;
        logic [AW-1:0] prev_addr;

        // Reset with no clock edge seen yet.
        #1;
        chk_all_zero("rst0");
        @(negedge wclk);
        wrst = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        chk_all_zero("idle");

        // Fill to full with the read pointer at zero.
        set_rptr(0);
        for (int i = 1; i <= 16; i++) begin
            step(1'b1, 1'b0);
            if (i == 12) begin
                chk("fill12_wafull", {31'd0, wafull}, 32'd1);
                chk("fill12_wlevel", {27'd0, wlevel}, 32'd12);
            end
        end
        chk("fill16_wfull", {31'd0, wfull}, 32'd1);
        chk("fill16_wlevel", {27'd0, wlevel}, 32'd16);
        chk("fill16_wptr", {27'd0, wptr}, 32'b11000);
        chk("fill16_waddr", {28'd0, waddr}, 32'd0);

        // Writes while full are dropped and flag overflow.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("ovf_wptr", {27'd0, wptr}, 32'b11000);
        chk("ovf_set", {31'd0, woverflow}, 32'd1);
        step(1'b0, 1'b1);
        chk("ovf_clr", {31'd0, woverflow}, 32'd0);
        step(1'b1, 1'b1);
        chk("ovf_set_wins", {31'd0, woverflow}, 32'd1);

        // Drain through the synchronised read pointer.
        set_rptr(4);
        step(1'b0, 1'b0);
        chk("drain4_wfull", {31'd0, wfull}, 32'd0);
        chk("drain4_wlevel", {27'd0, wlevel}, 32'd12);
        chk("drain4_wafull", {31'd0, wafull}, 32'd1);
        set_rptr(5);
        step(1'b0, 1'b0);
        chk("drain5_wlevel", {27'd0, wlevel}, 32'd11);
        chk("drain5_wafull", {31'd0, wafull}, 32'd0);

        // Reset mid-burst: 7 writes, then reset asserted during the 8th.
        pulse_reset("rst1");
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
        winc = 1'b1;
        pulse_reset("rst_burst");
        for (int i = 0; i < 5; i++) begin
            chk("resume_waddr", {28'd0, waddr}, i);
            step(1'b1, 1'b0);
        end

        // Wrap: 40 writes with the read pointer held two writes behind.
        pulse_reset("rst2");
        wraps = 0;
        prev_addr = waddr;
        for (int i = 0; i < 40; i++) begin
            set_rptr((m_wcnt >= 2) ? m_wcnt - 2 : 0);
            step(1'b1, 1'b0);
            if (prev_addr == AW'(DEPTH - 1) && waddr == '0) wraps++;
            prev_addr = waddr;
            if (i == 30) chk("wrap_wptr31", {27'd0, wptr}, 32'b10000);
            if (i == 31) chk("wrap_wptr32", {27'd0, wptr}, 32'b00000);
        end
        chk("wrap_count", wraps, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wptr_full_ctrl.md
# wptr_full_ctrl

Write-side pointer and flag controller for the dual-clock FIFO, running entirely in the write clock domain. It counts accepted writes, produces the binary RAM write address and the Gray-coded write pointer handed to the read-domain synchroniser, and compares against the already-synchronised read pointer. From that comparison it generates full, almost-full, fill level and a sticky overflow flag. It is the write-end counterpart of the read-pointer/empty logic and shares the same dual n-bit Gray pointer format.

## Interface
- ADDR_WIDTH, 4, RAM address width; FIFO depth = 2^ADDR_WIDTH; legal range ≥ 2
- AFULL_THRESH, 12, fill level at or above which wafull asserts; legal 1..2^ADDR_WIDTH
- wclk  in  1  write clock; all state on rising edge
- wrst  in  1  reset, asynchronous, active-high; clears all state immediately
- winc  in  1  write request from producer
- wclr_ovf  in  1  clears woverflow
- wq2_rptr  in  ADDR_WIDTH+1  read pointer (Gray), already 2-flop synchronised into wclk domain
- waddr  out  ADDR_WIDTH  RAM write address = wbin[ADDR_WIDTH-1:0]
- wptr  out  ADDR_WIDTH+1  write pointer, Gray, registered; goes to read-domain synchroniser
- wfull  out  1  FIFO full, registered
- wafull  out  1  almost full, registered
- wlevel  out  ADDR_WIDTH+1  fill level 0..2^ADDR_WIDTH, registered
- woverflow  out  1  sticky: a write was attempted while full

## Operation
- Internal wbin (ADDR_WIDTH+1 bits, binary) and wptr (Gray) update together on every clock.
- Accept = winc & ~wfull; wbinnext = wbin + accept, modulo 2^(ADDR_WIDTH+1); wgraynext = (wbinnext >> 1) ^ wbinnext.
- Full compare: wfull_next = (wgraynext == {~wq2_rptr[MSB:MSB-1], wq2_rptr[MSB-2:0]}); the top two bits are inverted, all other bits are equal.
- Read pointer to binary: rbin_s[i] = XOR of wq2_rptr[MSB:i]. This is purely combinational.
- Level: wlevel_next = wbinnext − rbin_s, modulo 2^(ADDR_WIDTH+1). The result never exceeds 2^ADDR_WIDTH when the inputs are legal.
- wafull_next = (wlevel_next ≥ AFULL_THRESH).
- woverflow: set when winc & wfull; cleared when wclr_ovf. If both occur in the same cycle, set wins.
- A write attempted while full is dropped. wbin, wptr and waddr hold; the RAM write enable is winc & ~wfull, generated outside this block.
- Wrap-around: wbin rolls from 2^(ADDR_WIDTH+1)−1 to 0. The Gray code changes a single bit, and the MSB distinguishes lap parity.
- Reset values: wbin=0, wptr=0, waddr=0, wfull=0, wafull=0, wlevel=0, woverflow=0. Reset during a burst discards all counts immediately; the pointers restart from 0 on the first edge after release. The system reset scheme keeps both domains' resets aligned.

## Timing
- All outputs are registered except waddr, which is a direct slice of the wbin register. No output has a combinational path from any input.
- Write accepted at edge N: waddr, wptr and wlevel show the new value after edge N.
- The write that fills the FIFO: wfull = 1 after that same edge N. There is no extra lag, so the cycle N+1 write is refused.
- The wafull update lands on the same edge as its corresponding wlevel update.
- Frees on the read side reach this block only via wq2_rptr, which lags by ≥ 2 wclk plus the read-side register. wfull and wlevel therefore stay pessimistic (full or high) until the change arrives.
- wq2_rptr changes before edge M: wfull, wafull and wlevel reflect it after edge M.
- Simultaneous write and read-pointer advance in one cycle: both terms are used in the same compare, and the level stays consistent.

## Test plan
- Reset: assert wrst mid-cycle with no clock edge → all outputs read 0 immediately. Release, idle 4 cycles → outputs remain 0.
- Fill (ADDR_WIDTH=4), wq2_rptr=0, winc high for 16 cycles:
  - after the 12th write, wafull=1 and wlevel=12;
  - after the 16th write, wfull=1, wlevel=16, wptr=5'b11000, waddr=0.
- Write while full: from the full state, winc=1 for 3 cycles → wptr, waddr and wlevel unchanged, woverflow=1. Pulse wclr_ovf → woverflow=0. Pulse wclr_ovf and winc together while full → woverflow stays 1.
- Drain: from full, set wq2_rptr=Gray(4)=5'b00110 → one edge later wfull=0, wlevel=12, wafull=1. Then wq2_rptr=Gray(5)=5'b00111 → wlevel=11, wafull=0.
- Wrap: 40 writes with wq2_rptr tracking the write pointer, held 2 writes behind → wfull never asserts. wptr passes 5'b10000 (wbin=31) and then 5'b00000 (wbin=32); waddr wraps 15→0 twice.
- Reset mid-burst: 7 writes, assert wrst for 1 cycle during the 8th → wptr=0 and wlevel=0 immediately. Resume writes with wq2_rptr=0 → waddr counts 0,1,2….
